// File: rtl/ldst_resp_scatter.sv
// ---------------------------------------------------------------------------
// ldst_resp_scatter
//
// Sits downstream of the thread coalescing unit. Coalesced cache-line
// commands are forwarded combinationally as line-aligned memory requests.
// Load metadata is held in an in-order pending FIFO. When a load response
// returns, the line is split back into per-thread register writebacks, one
// thread per cycle, lowest bitmap bit first.
//
// Ports
//   clk, rst               clock / asynchronous active-high reset
//   in_*                   coalesced command (valid/ready handshake)
//   mem_req_*              line-aligned memory request (valid/ready)
//   mem_rsp_*              load response line, in request order (valid/ready)
//   wb_*                   per-thread writeback (valid/ready), registered
//   pending_count          occupied pending-FIFO entries
//   rsp_orphan             sticky: a response arrived with no pending load
//   perf_wb_count/stall    only with LDST_RESP_SCATTER_PERF_EN defined:
//                          writeback handshakes / writeback stall cycles
//
// Build option
//   LDST_RESP_SCATTER_PERF_EN  adds the two 32-bit performance counters.
// ---------------------------------------------------------------------------
module ldst_resp_scatter #(
    parameter int CACHE_LINE_SIZE        = 32,
    parameter int NUM_MAX_COALESCED_CMDS = CACHE_LINE_SIZE / 4,
    parameter int BASE_ADDR_OFFSET       = $clog2(CACHE_LINE_SIZE),
    parameter int PENDING_DEPTH          = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [3:0]                                         in_block_id,
    input  logic [9:0]                                         in_base_tid,
    input  logic [NUM_MAX_COALESCED_CMDS-1:0]                  in_tid_bitmap,
    input  logic                                               in_write_enable,
    input  logic [CACHE_LINE_SIZE*8-1:0]                       in_write_data,
    input  logic [CACHE_LINE_SIZE-1:0]                         in_write_mask,
    input  logic [63:0]                                        in_address,
    input  logic [1:0]                                         in_size,
    input  logic [6:0]                                         in_ld_dest_reg,
    input  logic [NUM_MAX_COALESCED_CMDS*BASE_ADDR_OFFSET-1:0] in_address_map,
    output logic                                               mem_req_valid,
    input  logic                                               mem_req_ready,
    output logic                                               mem_req_write,
    output logic [63:0]                                        mem_req_addr,
    output logic [CACHE_LINE_SIZE*8-1:0]                       mem_req_data,
    output logic [CACHE_LINE_SIZE-1:0]                         mem_req_mask,
    input  logic                                               mem_rsp_valid,
    output logic                                               mem_rsp_ready,
    input  logic [CACHE_LINE_SIZE*8-1:0]                       mem_rsp_data,
    output logic                                               wb_valid,
    input  logic                                               wb_ready,
    output logic [3:0]                                         wb_block_id,
    output logic [9:0]                                         wb_tid,
    output logic [6:0]                                         wb_dest_reg,
    output logic [63:0]                                        wb_data,
    output logic [$clog2(PENDING_DEPTH):0]                     pending_count,
    output logic                                               rsp_orphan
`ifdef LDST_RESP_SCATTER_PERF_EN
    ,
    output logic [31:0]                                        perf_wb_count,
    output logic [31:0]                                        perf_wb_stall
`endif
);

    localparam int N      = NUM_MAX_COALESCED_CMDS;
    localparam int OFF    = BASE_ADDR_OFFSET;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int PTR_W  = $clog2(PENDING_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic { S_IDLE = 1'b0, S_SCATTER = 1'b1 } state_t;

    typedef struct packed {
        logic [3:0]       block_id;
        logic [9:0]       base_tid;
        logic [N-1:0]     bitmap;
        logic [1:0]       size;
        logic [6:0]       dest_reg;
        logic [N*OFF-1:0] addr_map;
    } entry_t;

    // Lowest set bit wins: scan downwards so the last hit is the lowest index.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // ---------------------------------------------------------------- FIFO
    entry_t             fifo_mem [PENDING_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               load_ok;
    logic               push;
    logic               pop;
    entry_t             push_entry;
    entry_t             head;

    assign fifo_full  = (count_q == CNT_W'(PENDING_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Loads need a free pending slot; stores never touch the FIFO. A pop in
    // the same cycle does not free a slot for a load (no full bypass).
    assign load_ok       = in_write_enable | ~fifo_full;
    assign mem_req_valid = in_valid & load_ok;
    assign in_ready      = mem_req_ready & load_ok;
    assign mem_req_write = in_write_enable;
    assign mem_req_addr  = in_address & ~(64'(CACHE_LINE_SIZE) - 64'd1);
    assign mem_req_data  = in_write_data;
    assign mem_req_mask  = in_write_mask;

    assign push = in_valid & in_ready & ~in_write_enable;
    assign pop  = mem_rsp_valid & mem_rsp_ready & ~fifo_empty;

    assign push_entry = '{block_id: in_block_id, base_tid: in_base_tid,
                          bitmap: in_tid_bitmap, size: in_size,
                          dest_reg: in_ld_dest_reg, addr_map: in_address_map};

    // Head is read combinationally so the response cycle can capture the
    // metadata together with the line and writeback can start next cycle.
    assign head = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pending_count = count_q;

    // ---------------------------------------------------------- scatter FSM
    state_t             state_q,    state_d;
    logic [N-1:0]       bitmap_q,   bitmap_d;
    logic [LINE_W-1:0]  line_q,     line_d;
    logic [3:0]         block_id_q, block_id_d;
    logic [9:0]         base_tid_q, base_tid_d;
    logic [1:0]         size_q,     size_d;
    logic [6:0]         dest_q,     dest_d;
    logic [N*OFF-1:0]   map_q,      map_d;
    logic               orphan_q,   orphan_d;
    logic [IDX_W-1:0]   wb_idx_q,   wb_idx_d;
    logic [9:0]         wb_tid_q,   wb_tid_d;
    logic [63:0]        wb_data_q,  wb_data_d;
    logic [OFF-1:0]     pick_off;
    logic [LINE_W-1:0]  pick_shifted;

    assign mem_rsp_ready = (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        line_d     = line_q;
        block_id_d = block_id_q;
        base_tid_d = base_tid_q;
        size_d     = size_q;
        dest_d     = dest_q;
        map_d      = map_q;
        orphan_d   = orphan_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rsp_valid) begin
                    if (!fifo_empty) begin
                        line_d     = mem_rsp_data;
                        bitmap_d   = head.bitmap;
                        block_id_d = head.block_id;
                        base_tid_d = head.base_tid;
                        size_d     = head.size;
                        dest_d     = head.dest_reg;
                        map_d      = head.addr_map;
                        // An empty bitmap is simply retired without writeback.
                        if (head.bitmap != '0) state_d = S_SCATTER;
                    end else begin
                        orphan_d = 1'b1;
                    end
                end
            end
            S_SCATTER: begin
                if (wb_ready) begin
                    bitmap_d = bitmap_q & ~(N'(1) << wb_idx_q);
                    if (bitmap_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next writeback is computed from next-cycle state so the wb_* outputs
    // come straight from registers and hold steady while stalled.
    always_comb begin
        wb_idx_d     = lowest_set(bitmap_d);
        pick_off     = map_d[int'(wb_idx_d)*OFF +: OFF];
        // Logical shift pulls zeros in, so bytes past the line end read 0.
        pick_shifted = line_d >> {pick_off, 3'b000};
        wb_data_d    = pick_shifted[63:0] & size_mask(size_d);
        wb_tid_d     = base_tid_d + 10'(wb_idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bitmap_q   <= '0;
            line_q     <= '0;
            block_id_q <= '0;
            base_tid_q <= '0;
            size_q     <= '0;
            dest_q     <= '0;
            map_q      <= '0;
            orphan_q   <= 1'b0;
            wb_idx_q   <= '0;
            wb_tid_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            line_q     <= line_d;
            block_id_q <= block_id_d;
            base_tid_q <= base_tid_d;
            size_q     <= size_d;
            dest_q     <= dest_d;
            map_q      <= map_d;
            orphan_q   <= orphan_d;
            if (state_d == S_SCATTER) begin
                wb_idx_q  <= wb_idx_d;
                wb_tid_q  <= wb_tid_d;
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign wb_valid    = (state_q == S_SCATTER);
    assign wb_block_id = block_id_q;
    assign wb_tid      = wb_tid_q;
    assign wb_dest_reg = dest_q;
    assign wb_data     = wb_data_q;
    assign rsp_orphan  = orphan_q;

`ifdef LDST_RESP_SCATTER_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (wb_valid & wb_ready)  perf_cnt_q   <= perf_cnt_q + 32'd1;
            if (wb_valid & ~wb_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_wb_count = perf_cnt_q;
    assign perf_wb_stall = perf_stall_q;
`endif

endmodule
